// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - receive-side sequence checker for a free-running counter stream
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count
);

  // Run counter only needs to reach LOCK_CNT.
  localparam int RUN_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t             state_q;
  logic [RUN_W-1:0]   run_q;
  logic [WIDTH-1:0]   expected_q;
  logic [ERR_W-1:0]   err_count_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic               wrap_pulse_q;

  logic [WIDTH-1:0]   expected_d;
  logic [RUN_W-1:0]   run_d;
  logic [ERR_W-1:0]   err_count_d;
  logic               match_d;
  logic               lock_reached_d;

  // Helper next values: successor of the sample, incremented run, saturating error count.
  always_comb begin
    expected_d     = in_count + WIDTH'(1);
    run_d          = run_q + RUN_W'(1);
    match_d        = (in_count == expected_q);
    lock_reached_d = (run_d >= RUN_W'(LOCK_CNT));
    err_count_d    = (err_count_q == {ERR_W{1'b1}}) ? err_count_q : err_count_q + ERR_W'(1);
  end

  // Lock FSM with registered outputs; reset beats clear, clear beats a sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      run_q        <= '0;
      expected_q   <= '0;
      err_count_q  <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      if (clear) begin
        state_q     <= HUNT;
        run_q       <= '0;
        expected_q  <= '0;
        err_count_q <= '0;
        locked_q    <= 1'b0;
      end else if (in_valid) begin
        expected_q <= expected_d;
        case (state_q)
          HUNT: begin
            run_q   <= '0;
            state_q <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match_d) begin
              if (lock_reached_d) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                run_q    <= RUN_W'(LOCK_CNT);
              end else begin
                run_q <= run_d;
              end
            end else begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            if (match_d) begin
              wrap_pulse_q <= (in_count == '0);
            end else begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
              run_q       <= '0;
              locked_q    <= 1'b0;
              state_q     <= ACQUIRE;
            end
          end
          default: begin
            state_q  <= HUNT;
            run_q    <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign expected   = expected_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - directed bench for count_seq_checker
module tb_count_seq_checker;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_count;
  logic       locked;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [3:0] expected;
  logic [7:0] err_count;

  int tests;
  int fails;

  count_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_count   (in_count),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .expected   (expected),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, observe 1 ns after the rising edge.
  task automatic step(input logic v, input int c, input logic clr = 1'b0);
    @(negedge clk);
    in_valid = v;
    in_count = c[3:0];
    clear    = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic l, input logic e, input logic w,
                         input logic [3:0] x, input logic [7:0] ec);
    chk({tag, ".locked"},     locked,     l);
    chk({tag, ".err_pulse"},  err_pulse,  e);
    chk({tag, ".wrap_pulse"}, wrap_pulse, w);
    chk({tag, ".expected"},   expected,   x);
    chk({tag, ".err_count"},  err_count,  ec);
  endtask

  initial begin
    int cur;
    tests    = 0;
    fails    = 0;
    reset_n  = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_count = '0;

    // Reset held three cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_hold", 0, 0, 0, 4'd0, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0);
    chk_all("reset_rel", 0, 0, 0, 4'd0, 8'd0);

    // Lock on 0,1,2.
    step(1, 0);  chk_all("lock_s0", 0, 0, 0, 4'd1, 8'd0);
    step(1, 1);  chk_all("lock_s1", 0, 0, 0, 4'd2, 8'd0);
    step(1, 2);  chk_all("lock_s2", 1, 0, 0, 4'd3, 8'd0);

    // Wrap 14,15,0,1 while locked.
    for (int v = 3; v <= 14; v++) step(1, v);
    chk_all("wrap_14", 1, 0, 0, 4'd15, 8'd0);
    step(1, 15); chk_all("wrap_15", 1, 0, 0, 4'd0, 8'd0);
    step(1, 0);  chk_all("wrap_0",  1, 0, 1, 4'd1, 8'd0);
    step(1, 1);  chk_all("wrap_1",  1, 0, 0, 4'd2, 8'd0);

    // Break 5,6,9,10,11.
    for (int v = 2; v <= 6; v++) step(1, v);
    chk_all("brk_6", 1, 0, 0, 4'd7, 8'd0);
    step(1, 9);  chk_all("brk_9",  0, 1, 0, 4'd10, 8'd1);
    step(1, 10); chk_all("brk_10", 0, 0, 0, 4'd11, 8'd1);
    step(1, 11); chk_all("brk_11", 1, 0, 0, 4'd12, 8'd1);

    // Valid gap is not an error; a repeated value is.
    step(1, 12);
    repeat (4) step(0, 5);
    chk_all("gap_idle", 1, 0, 0, 4'd13, 8'd1);
    step(1, 13); chk_all("gap_13",  1, 0, 0, 4'd14, 8'd1);
    step(1, 13); chk_all("rep_13",  0, 1, 0, 4'd14, 8'd2);

    // Relock, then clear with a coincident sample that must be dropped.
    step(1, 14);
    step(1, 15); chk_all("pre_clr", 1, 0, 0, 4'd0, 8'd2);
    step(1, 0, 1'b1);
    chk_all("clear", 0, 0, 0, 4'd0, 8'd0);
    step(1, 7);  chk_all("hunt_7", 0, 0, 0, 4'd8, 8'd0);
    step(1, 8);
    step(1, 9);  chk_all("hunt_9", 1, 0, 0, 4'd10, 8'd0);

    // Asynchronous reset mid-cycle after building up state.
    step(1, 3);  chk_all("pre_rst_brk", 0, 1, 0, 4'd4, 8'd1);
    step(1, 4);
    step(1, 5);  chk_all("pre_rst_lock", 1, 0, 0, 4'd6, 8'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 4'd0, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 300 breaks saturate the 8-bit error count at 255.
    step(1, 0);
    cur = 1;
    for (int i = 0; i < 300; i++) begin
      step(1, cur);
      step(1, cur + 1);
      step(1, cur + 5);
      cur = (cur + 6) % 16;
      if (i == 0)   chk("sat_first",  err_count, 8'd1);
      if (i == 254) chk("sat_255",    err_count, 8'd255);
      if (i == 255) chk("sat_hold",   err_count, 8'd255);
    end
    chk("sat_end_pulse", err_pulse, 1'b1);
    chk("sat_end_cnt",   err_count, 8'd255);
    chk("sat_end_lock",  locked,    1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
